// File: rtl/set_match_seq_if.sv
// Bus interface for set_match_seq: table write port, query handshake and
// result handshake. The wr_hi range bound exists only when the
// SET_MATCH_RANGE_EN macro is defined.
interface set_match_seq_if #(
    parameter int W     = 8,
    parameter int DEPTH = 8,
    parameter int IW    = $clog2(DEPTH)
);
    logic          wr_en;
    logic [IW-1:0] wr_idx;
    logic [W-1:0]  wr_data;
`ifdef SET_MATCH_RANGE_EN
    logic [W-1:0]  wr_hi;
`endif
    logic          inv_all;
    logic          wr_err;
    logic          q_valid;
    logic          q_ready;
    logic [W-1:0]  q_key;
    logic          r_valid;
    logic          r_ready;
    logic          r_hit;
    logic [IW-1:0] r_idx;
    logic          busy;

`ifdef SET_MATCH_RANGE_EN
    modport master (
        output wr_en, wr_idx, wr_data, wr_hi, inv_all, q_valid, q_key, r_ready,
        input  wr_err, q_ready, r_valid, r_hit, r_idx, busy
    );
    modport slave (
        input  wr_en, wr_idx, wr_data, wr_hi, inv_all, q_valid, q_key, r_ready,
        output wr_err, q_ready, r_valid, r_hit, r_idx, busy
    );
`else
    modport master (
        output wr_en, wr_idx, wr_data, inv_all, q_valid, q_key, r_ready,
        input  wr_err, q_ready, r_valid, r_hit, r_idx, busy
    );
    modport slave (
        input  wr_en, wr_idx, wr_data, inv_all, q_valid, q_key, r_ready,
        output wr_err, q_ready, r_valid, r_hit, r_idx, busy
    );
`endif
endinterface

// File: rtl/set_match_seq.sv
// set_match_seq: sequenced set-membership engine. A table of DEPTH entries is
// scanned one entry per clock, lowest index first, through a single shared
// comparator. Returns hit flag and lowest matching index.
// Optional feature macro: SET_MATCH_RANGE_EN -- entries hold an inclusive
// [lo, hi] range instead of a single value.
module set_match_seq #(
    parameter int W     = 8,
    parameter int DEPTH = 8
) (
    input  logic            clk,
    input  logic            clr,
    set_match_seq_if.slave  bus
);
    localparam int IW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, SCAN, RESP} state_t;

    state_t        state, state_nx;
    logic [W-1:0]  entry_lo [DEPTH];
`ifdef SET_MATCH_RANGE_EN
    logic [W-1:0]  entry_hi [DEPTH];
`endif
    logic [DEPTH-1:0] valid;
    logic [IW-1:0] ptr;
    logic [W-1:0]  key;
    logic          r_valid_q;
    logic          r_hit_q;
    logic [IW-1:0] r_idx_q;
    logic          wr_err_q;
    logic          match_now;
    logic          last_entry;
    logic          accept;
    logic          r_done;
    logic          tbl_req;
    logic          wr_ok;
    logic          q_ready_c;
    logic          busy_c;

    assign accept     = (state == IDLE) && bus.q_valid;
    assign r_done     = r_valid_q && bus.r_ready;
    assign tbl_req    = bus.wr_en || bus.inv_all;
    assign wr_ok      = (state == IDLE) && bus.wr_en && !bus.inv_all;
    assign last_entry = (ptr == IW'(DEPTH - 1));

    // Shared comparator: does the entry under the scan pointer match the key.
    always_comb begin
        // NOTE: every signal driven here gets a default first so no latch is inferred.
        match_now = 1'b0;
`ifdef SET_MATCH_RANGE_EN
        match_now = valid[ptr] && (entry_lo[ptr] <= key) && (key <= entry_hi[ptr]);
`else
        match_now = valid[ptr] && (entry_lo[ptr] == key);
`endif
    end

    // State register; clr aborts any scan in flight.
    always_ff @(posedge clk or posedge clr) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (clr) state <= IDLE;
        else     state <= state_nx;
    end

    // Next-state logic: IDLE -> SCAN -> RESP -> IDLE.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (bus.q_valid) state_nx = SCAN;
            SCAN:    if (match_now || last_entry) state_nx = RESP;
            RESP:    if (r_done) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // State-decoded outputs.
    always_comb begin
        q_ready_c = (state == IDLE);
        busy_c    = (state != IDLE);
    end

    // Entry storage; written only in IDLE and only when not invalidating.
    always_ff @(posedge clk) begin
        // NOTE: table data has no reset; the valid bits alone define table contents.
        if (wr_ok) begin
            entry_lo[bus.wr_idx] <= bus.wr_data;
`ifdef SET_MATCH_RANGE_EN
            entry_hi[bus.wr_idx] <= bus.wr_hi;
`endif
        end
    end

    // Valid bits: inv_all wins over a same-cycle write; both ignored outside IDLE.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            valid <= '0;
        end else if (state == IDLE) begin
            if (bus.inv_all)    valid <= '0;
            else if (bus.wr_en) valid[bus.wr_idx] <= 1'b1;
        end
    end

    // Dropped-write flag, one cycle after the rejected request.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) wr_err_q <= 1'b0;
        else     wr_err_q <= tbl_req && (state != IDLE);
    end

    // Key capture and scan pointer.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            ptr <= '0;
            key <= '0;
        end else if (accept) begin
            ptr <= '0;
            key <= bus.q_key;
        end else if (state == SCAN && !match_now && !last_entry) begin
            ptr <= ptr + 1'b1;
        end
    end

    // Scan result; held until the next scan finishes.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_hit_q <= 1'b0;
            r_idx_q <= '0;
        end else if (state == SCAN && match_now) begin
            r_hit_q <= 1'b1;
            r_idx_q <= ptr;
        end else if (state == SCAN && last_entry) begin
            r_hit_q <= 1'b0;
            r_idx_q <= '0;
        end
    end

    // Result valid rises one cycle after entering RESP, drops after handshake.
    always_ff @(posedge clk or posedge clr) begin
        if (clr)                         r_valid_q <= 1'b0;
        else if (r_done)                 r_valid_q <= 1'b0;
        else if (state == RESP)          r_valid_q <= 1'b1;
    end

    assign bus.q_ready = q_ready_c;
    assign bus.busy    = busy_c;
    assign bus.wr_err  = wr_err_q;
    assign bus.r_valid = r_valid_q;
    assign bus.r_hit   = r_hit_q;
    assign bus.r_idx   = r_idx_q;
endmodule

// File: tb/tb_set_match_seq.sv
// Directed testbench for set_match_seq. Expected results are queued when a
// query is issued and compared when r_valid appears. Inputs change and outputs
// are sampled on the falling edge.
module tb_set_match_seq;
    localparam int W     = 8;
    localparam int DEPTH = 8;
    localparam int IW    = $clog2(DEPTH);
    localparam int PER   = 10;

    typedef struct {
        logic          hit;
        logic [IW-1:0] idx;
        int            lat;
    } exp_t;

    logic clk = 1'b0;
    logic clr;
    exp_t sb [$];
    int   checks   = 0;
    int   failures = 0;
    time  t_acc;

    always #(PER/2) clk = ~clk;

    set_match_seq_if #(.W(W), .DEPTH(DEPTH)) bus ();
    set_match_seq #(.W(W), .DEPTH(DEPTH)) dut (.clk(clk), .clr(clr), .bus(bus));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [IW-1:0] idx, input logic [W-1:0] lo, input logic [W-1:0] hi);
        bus.wr_en   = 1'b1;
        bus.wr_idx  = idx;
        bus.wr_data = lo;
`ifdef SET_MATCH_RANGE_EN
        bus.wr_hi   = hi;
`endif
        @(negedge clk);
        bus.wr_en   = 1'b0;
        check("wr_err_idle_write", bus.wr_err, 0);
    endtask

    task automatic start_query(input logic [W-1:0] k, input logic hit,
                               input logic [IW-1:0] idx, input int lat);
        check("q_ready_before_accept", bus.q_ready, 1);
        bus.q_valid = 1'b1;
        bus.q_key   = k;
        sb.push_back('{hit: hit, idx: idx, lat: lat});
        @(posedge clk);
        t_acc = $time;
        @(negedge clk);
        bus.q_valid = 1'b0;
    endtask

    task automatic wait_result(input string tag);
        exp_t e;
        int   lat;
        bit   seen = 1'b0;
        for (int n = 0; n < 40; n++) begin
            if (bus.r_valid === 1'b1) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check({tag, "_timeout"}, 32'(seen), 1);
        if (seen && sb.size() > 0) begin
            lat = int'(($time - t_acc - PER/2) / PER);
            e   = sb.pop_front();
            check({tag, "_hit"}, 32'(bus.r_hit), 32'(e.hit));
            check({tag, "_idx"}, 32'(bus.r_idx), 32'(e.idx));
            check({tag, "_latency"}, 32'(lat), 32'(e.lat));
        end
    endtask

    task automatic handshake(input string tag);
        bus.r_ready = 1'b1;
        @(negedge clk);
        bus.r_ready = 1'b0;
        check({tag, "_rvalid_drop"}, bus.r_valid, 0);
        check({tag, "_idle"}, bus.busy, 0);
    endtask

    task automatic query(input logic [W-1:0] k, input logic hit,
                         input logic [IW-1:0] idx, input int lat, input string tag);
        start_query(k, hit, idx, lat);
        wait_result(tag);
        handshake(tag);
    endtask

    initial begin
        int rv_seen;
        clr         = 1'b1;
        bus.wr_en   = 1'b0;
        bus.wr_idx  = '0;
        bus.wr_data = '0;
`ifdef SET_MATCH_RANGE_EN
        bus.wr_hi   = '0;
`endif
        bus.inv_all = 1'b0;
        bus.q_valid = 1'b0;
        bus.q_key   = '0;
        bus.r_ready = 1'b0;
        #2;
        check("rst_busy", bus.busy, 0);
        check("rst_q_ready", bus.q_ready, 1);
        check("rst_r_valid", bus.r_valid, 0);
        check("rst_r_hit", bus.r_hit, 0);
        check("rst_r_idx", 32'(bus.r_idx), 0);
        check("rst_wr_err", bus.wr_err, 0);
        @(negedge clk);
        clr = 1'b0;
        @(negedge clk);

        // Empty table always misses; miss latency DEPTH+1.
        query(8'h00, 1'b0, '0, DEPTH + 1, "empty_q00");

        // Fill table, then clear asynchronously mid-scan.
        for (int i = 0; i < DEPTH - 1; i++) wr(IW'(i), 8'(8'h80 + i), 8'(8'h80 + i));
        wr(IW'(DEPTH - 1), 8'h10, 8'h10);
        start_query(8'h10, 1'b1, IW'(DEPTH - 1), DEPTH + 1);
        @(negedge clk);
        @(negedge clk);
        #1 clr = 1'b1;
        #1;
        check("clr_busy", bus.busy, 0);
        check("clr_q_ready", bus.q_ready, 1);
        check("clr_r_valid", bus.r_valid, 0);
        #1 clr = 1'b0;
        sb.delete();
        @(negedge clk);
        rv_seen = 0;
        for (int i = 0; i < 12; i++) begin
            if (bus.r_valid === 1'b1) rv_seen++;
            @(negedge clk);
        end
        check("clr_no_result", 32'(rv_seen), 0);
        query(8'h10, 1'b0, '0, DEPTH + 1, "post_clr_q10");

        // Duplicate value: lowest index wins, hit at k gives latency k+2.
        wr(3'd3, 8'hA5, 8'hA5);
        wr(3'd6, 8'hA5, 8'hA5);
        query(8'hA5, 1'b1, 3'd3, 5, "dup_qA5");

        // Hold r_ready low: result stable and no new query accepted.
        start_query(8'hA5, 1'b1, 3'd3, 5);
        wait_result("hold_qA5");
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("hold_r_valid", bus.r_valid, 1);
            check("hold_r_hit", bus.r_hit, 1);
            check("hold_r_idx", 32'(bus.r_idx), 3);
            check("hold_q_ready", bus.q_ready, 0);
        end
        handshake("hold");
        query(8'hA5, 1'b1, 3'd3, 5, "after_hold_qA5");

        // Write during SCAN is dropped and flagged.
        start_query(8'h33, 1'b0, '0, DEPTH + 1);
        bus.wr_en   = 1'b1;
        bus.wr_idx  = 3'd2;
        bus.wr_data = 8'h33;
`ifdef SET_MATCH_RANGE_EN
        bus.wr_hi   = 8'h33;
`endif
        @(negedge clk);
        bus.wr_en = 1'b0;
        check("scan_wr_err_pulse", bus.wr_err, 1);
        @(negedge clk);
        check("scan_wr_err_clear", bus.wr_err, 0);
        wait_result("scan_wr_q33");
        handshake("scan_wr");
        query(8'h33, 1'b0, '0, DEPTH + 1, "recheck_q33");

        // inv_all beats same-cycle wr_en.
        bus.inv_all = 1'b1;
        bus.wr_en   = 1'b1;
        bus.wr_idx  = 3'd0;
        bus.wr_data = 8'h55;
`ifdef SET_MATCH_RANGE_EN
        bus.wr_hi   = 8'h55;
`endif
        @(negedge clk);
        bus.inv_all = 1'b0;
        bus.wr_en   = 1'b0;
        check("inv_wr_err", bus.wr_err, 0);
        query(8'h55, 1'b0, '0, DEPTH + 1, "inv_q55");
        query(8'hA5, 1'b0, '0, DEPTH + 1, "inv_qA5");

        // Last entry hit: latency DEPTH+1.
        wr(IW'(DEPTH - 1), 8'hEE, 8'hEE);
        query(8'hEE, 1'b1, IW'(DEPTH - 1), DEPTH + 1, "last_qEE");

`ifdef SET_MATCH_RANGE_EN
        // Inclusive range bounds; inverted range never matches.
        bus.inv_all = 1'b1;
        @(negedge clk);
        bus.inv_all = 1'b0;
        wr(3'd0, 8'h20, 8'h2F);
        wr(3'd1, 8'h40, 8'h30);
        query(8'h20, 1'b1, 3'd0, 2, "rng_q20");
        query(8'h2F, 1'b1, 3'd0, 2, "rng_q2F");
        query(8'h30, 1'b0, '0, DEPTH + 1, "rng_q30");
        query(8'h35, 1'b0, '0, DEPTH + 1, "rng_q35");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
